// File: rtl/mmio_uart_tx_if.sv
`timescale 1ns/1ps
// Core-side data bus view of the UART TX register window.
// The core drives address/data/strobe; the block returns select and read data.
interface mmio_uart_tx_if;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic        sel;
  logic [31:0] rdata;

  modport master (
    output adr,
    output writedata,
    output memwrite,
    input  sel,
    input  rdata
  );

  modport slave (
    input  adr,
    input  writedata,
    input  memwrite,
    output sel,
    output rdata
  );
endinterface

// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
// Memory-mapped 8N1 UART transmitter: register window decode, byte FIFO,
// and a START/DATA/STOP serialiser whose bit period is latched per frame.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd10
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          txd
);

  localparam int unsigned   PW         = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW         = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [15:0]   r_div;
  logic [15:0]   r_div_q;
  logic [15:0]   r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_ovf;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_sel;
  logic          w_wr;
  logic          w_push;
  logic          w_push_ok;
  logic          w_full;
  logic          w_empty;
  logic          w_busy;
  logic          w_bit_end;
  logic          w_pop;
  logic [7:0]    w_head;
  logic [15:0]   w_div_eff;
  logic [31:0]   w_count_ext;
  logic [2:0]    w_count3;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_sel       = (bus.adr[31:4] == BASE_ADDR[31:4]);
  assign w_wr        = w_sel && bus.memwrite;
  assign w_push      = w_wr && (bus.adr[3:2] == 2'd0);
  assign w_full      = (r_count == FULL_COUNT);
  assign w_empty     = (r_count == CW'(0));
  assign w_push_ok   = w_push && !w_full;
  assign w_busy      = (r_state != S_IDLE);
  assign w_bit_end   = (r_timer == 16'd0);
  // Pops happen only on a frame start: from IDLE, or straight out of the last STOP cycle.
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head      = r_mem[r_rd_ptr];
  assign w_div_eff   = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_count_ext = 32'(r_count);
  assign w_count3    = (w_count_ext > 32'd7) ? 3'd7 : w_count_ext[2:0];
  assign w_status    = {26'd0, w_count3, r_ovf, w_busy, w_empty};
  assign w_unused    = ^{bus.adr[1:0], bus.writedata[31:16]};

  // Register read mux, combinational so the core sees it in the address cycle.
  always_comb begin
    w_rdata = 32'd0;
    if (w_sel) begin
      case (bus.adr[3:2])
        2'd1:    w_rdata = w_status;
        2'd2:    w_rdata = {16'd0, r_div};
        default: w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  assign bus.sel   = w_sel;
  assign bus.rdata = w_rdata;
  assign txd       = r_txd;

  // TX FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem    <= '{default: 8'd0};
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= bus.writedata[7:0];
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Divisor register and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= DIV_RESET;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && (bus.adr[3:2] == 2'd2)) begin
        r_div <= bus.writedata[15:0];
      end
      // A full-FIFO push is dropped even when a pop frees a slot on the same edge.
      if (w_push && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (bus.adr[3:2] == 2'd1) && bus.writedata[2]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Serialiser FSM; txd is registered and forced high by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_div_q   <= 16'd1;
      r_timer   <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_div_q   <= w_div_eff;
            r_timer   <= w_div_eff - 16'd1;
            r_bit_idx <= 3'd0;
            r_txd     <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_timer <= r_div_q - 16'd1;
            r_txd   <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= r_div_q - 16'd1;
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_txd     <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift   <= w_head;
              r_div_q   <= w_div_eff;
              r_timer   <= w_div_eff - 16'd1;
              r_bit_idx <= 3'd0;
              r_txd     <= 1'b0;
              r_state   <= S_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
// Directed bench for mmio_uart_tx: a register/decode vector table plus
// hand-written serial-frame, overflow and reset-abort sequences.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX     = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_DIV    = 32'hFFFF_0008;

  logic clk;
  logic reset;
  logic txd;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR  (32'hFFFF_0000),
    .FIFO_DEPTH (4),
    .DIV_RESET  (16'd10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        we;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [16];
  int   errors = 0;
  int   checks = 0;
  bit   rec_en = 1'b0;
  bit   rec_q [$];
  bit   exp_q [$];

  // txd recorder, sampled mid-low-phase.
  always @(negedge clk) begin
    if (rec_en) rec_q.push_back(txd);
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.adr       = a;
    bus.writedata = d;
    bus.memwrite  = 1'b1;
    @(negedge clk);
    bus.memwrite  = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.adr = a;
    #1;
    check32(name, bus.rdata, exp);
  endtask

  task automatic add_bits(input bit v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input int d);
    add_bits(1'b0, d);
    for (int i = 0; i < 8; i++) add_bits(b[i], d);
    add_bits(1'b1, d);
  endtask

  task automatic capture(input string name, input int k);
    for (int c = 0; (c < 400) && (rec_q.size() < k); c++) begin
      @(negedge clk);
      #1;
    end
    rec_en = 1'b0;
    check32($sformatf("%s_len", name), 32'(rec_q.size()), 32'(k));
    for (int i = 0; (i < k) && (i < rec_q.size()) && (i < exp_q.size()); i++) begin
      check32($sformatf("%s_bit%0d", name, i), {31'd0, rec_q[i]}, {31'd0, exp_q[i]});
    end
    rec_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vecs[0]  = '{32'hFFFF_0004, 32'h0,         1'b0, 1'b1, 32'h0000_0001};
    vecs[1]  = '{32'hFFFF_0008, 32'h0,         1'b0, 1'b1, 32'h0000_000A};
    vecs[2]  = '{32'hFFFF_0000, 32'h0,         1'b0, 1'b1, 32'h0000_0000};
    vecs[3]  = '{32'hFFFF_000C, 32'h0,         1'b0, 1'b1, 32'h0000_0000};
    vecs[4]  = '{32'h1000_0000, 32'h0,         1'b0, 1'b0, 32'h0000_0000};
    vecs[5]  = '{32'h1000_0000, 32'h55,        1'b1, 1'b0, 32'h0000_0000};
    vecs[6]  = '{32'h1000_0004, 32'h0,         1'b0, 1'b0, 32'h0000_0000};
    vecs[7]  = '{32'hFFFF_0004, 32'h0,         1'b0, 1'b1, 32'h0000_0001};
    vecs[8]  = '{32'hFFFF_000C, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000};
    vecs[9]  = '{32'hFFFF_0009, 32'h1234_ABCD, 1'b1, 1'b1, 32'h0000_000A};
    vecs[10] = '{32'hFFFF_000B, 32'h0,         1'b0, 1'b1, 32'h0000_ABCD};
    vecs[11] = '{32'hFFFF_0008, 32'h0000_000A, 1'b1, 1'b1, 32'h0000_ABCD};
    vecs[12] = '{32'hFFFF_0006, 32'h0,         1'b0, 1'b1, 32'h0000_0001};
    vecs[13] = '{32'hFFFF_0008, 32'h0,         1'b0, 1'b1, 32'h0000_000A};
    vecs[14] = '{32'hFFFF_0010, 32'h0,         1'b0, 1'b0, 32'h0000_0000};
    vecs[15] = '{32'hFFFE_FFF4, 32'h0,         1'b0, 1'b0, 32'h0000_0000};

    bus.adr       = 32'h0;
    bus.writedata = 32'h0;
    bus.memwrite  = 1'b0;
    reset         = 1'b1;
    #1 reset      = 1'b0;
    repeat (3) @(negedge clk);
    check32("reset_txd", {31'd0, txd}, 32'd1);
    reset = 1'b1;

    // Register map and address decode table.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.adr       = vecs[i].adr;
      bus.writedata = vecs[i].wdata;
      bus.memwrite  = vecs[i].we;
      #1;
      check32($sformatf("vec%0d_sel", i), {31'd0, bus.sel}, {31'd0, vecs[i].exp_sel});
      check32($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
    end
    @(negedge clk);
    bus.memwrite = 1'b0;

    // Single byte 0xA5 at 4 clocks per bit.
    bus_write(A_DIV, 32'd4);
    bus_write(A_TX, 32'hA5);
    bus.adr = A_STATUS;
    #1;
    check32("single_status_queued", bus.rdata, 32'h08);
    rec_en = 1'b1;
    add_frame(8'hA5, 4);
    add_bits(1'b1, 2);
    capture("single", 42);
    read_check("single_idle_status", A_STATUS, 32'h1);

    // Back-to-back frames at 1 clock per bit.
    bus_write(A_DIV, 32'd1);
    bus_write(A_TX, 32'h00);
    #1 rec_en = 1'b1;
    bus_write(A_TX, 32'hFF);
    add_frame(8'h00, 1);
    add_frame(8'hFF, 1);
    add_bits(1'b1, 4);
    capture("b2b", 24);

    // DIV rewritten while the first frame is in DATA.
    bus_write(A_DIV, 32'd2);
    bus_write(A_TX, 32'h0F);
    #1 rec_en = 1'b1;
    bus_write(A_TX, 32'h3C);
    bus_write(A_DIV, 32'd3);
    add_frame(8'h0F, 2);
    add_frame(8'h3C, 3);
    add_bits(1'b1, 4);
    capture("divchg", 54);
    read_check("divchg_div", A_DIV, 32'h3);

    // Six consecutive pushes at DIV=100: one pops, four queue, one overflows.
    bus_write(A_DIV, 32'd100);
    @(negedge clk);
    bus.adr      = A_TX;
    bus.memwrite = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.writedata = 32'(i + 1);
      @(negedge clk);
    end
    bus.memwrite = 1'b0;
    read_check("ovf_status", A_STATUS, 32'h26);
    bus_write(A_STATUS, 32'h4);
    read_check("ovf_cleared", A_STATUS, 32'h22);
    check32("ovf_txd_start", {31'd0, txd}, 32'd0);

    // Reset mid-frame aborts the frame and empties the FIFO.
    @(negedge clk);
    reset   = 1'b0;
    bus.adr = A_STATUS;
    #1;
    check32("abort_txd", {31'd0, txd}, 32'd1);
    check32("abort_status", bus.rdata, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    read_check("abort_div", A_DIV, 32'hA);
    repeat (5) @(negedge clk);
    read_check("abort_idle_status", A_STATUS, 32'h1);
    check32("abort_idle_txd", {31'd0, txd}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
